layer_serializer: RTL and testbench
===================================

Name: layer_serializer

Overview:
Downstream stage of a layer of neuron instances. All neurons of a layer assert output_valid in the same cycle. This block captures the parallel outputs and streams them one word per cycle into the next layer's serial input port (my_input/input_valid). On the final layer it can also report the argmax as the classification result.

Parameters:
NEURON_NUM, 30, number of neurons in the driving layer; must be >= 2
DATA_WIDTH, 16, width of each neuron output word (signed fixed point)
IDX_WIDTH, $clog2(NEURON_NUM), localparam; width of the element index and counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
neuron_data  in  NEURON_NUM*DATA_WIDTH  packed neuron outputs; neuron k occupies [k*DATA_WIDTH +: DATA_WIDTH]
neuron_valid  in  NEURON_NUM  per-neuron output_valid
out_data  out  DATA_WIDTH  serial word to the next layer's my_input
out_valid  out  1  drives the next layer's input_valid
out_last  out  1  high with the final word (index NEURON_NUM-1)
busy  out  1  high while in SHIFT
overflow  out  1  sticky; a capture was dropped
desync  out  1  sticky; neuron_valid was partially set
max_idx  out  IDX_WIDTH  argmax index (only when SER_ARGMAX_EN is defined)
max_val  out  DATA_WIDTH  argmax value (only when SER_ARGMAX_EN is defined)
max_valid  out  1  one-cycle result strobe (only when SER_ARGMAX_EN is defined)

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, capture register 0. Reset asserted mid-stream aborts the stream immediately; no partial tail is emitted after release.
- Capture condition: &neuron_valid. Any nonzero pattern that is not all-ones sets desync (sticky) and is otherwise ignored.
- FSM states:
  - IDLE: on capture, register neuron_data, set counter=0, go to SHIFT.
  - SHIFT: each cycle assert out_valid, with out_data = word[counter] and counter incrementing.
  - When counter==NEURON_NUM-1, assert out_last, then return to IDLE, unless a capture occurs in that same cycle (see back-to-back).
- Registered outputs. If capture is sampled at edge T, word 0 appears in the cycle after T. Exactly NEURON_NUM consecutive out_valid cycles follow, with no gaps.
- busy=1 in every SHIFT cycle.
- Back-to-back: a capture in the out_last cycle is accepted. The new vector starts the next cycle with counter=0, and out_valid stays continuous.
- Capture during SHIFT in any non-last cycle: the vector is dropped, overflow is set (sticky until reset), and the current stream continues unaffected.
- Word order is index 0 first, so the next layer's weight address 0 corresponds to neuron 0.
- No backpressure: the consumer must accept one word per cycle.

Optional Feature:
Macro SER_ARGMAX_EN.
- Defined:
  - A running signed maximum is tracked over streamed words. It is initialised from word 0.
  - It is replaced only on a strictly greater value, so ties keep the lowest index.
  - max_idx/max_val update in the cycle after out_last, and max_valid pulses for 1 cycle in that same cycle. They hold until the next result.
  - A back-to-back stream restarts tracking without corrupting the previous result.
- Undefined: the three ports and the tracking logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package/include: DATA_WIDTH default, a helper for the NEURON_NUM-to-IDX_WIDTH computation, and the FSM state encodings (IDLE=0, SHIFT=1).
- Sub-module: argmax_tracker. Inputs clk, rst_n, data, valid, first, last; outputs idx, val, strobe. Instantiated only under SER_ARGMAX_EN.

Test Plan:
1. NEURON_NUM=4, words {0x0010,0x0020,0x0030,0x0040} all-valid at edge T -> out_data 0x0010..0x0040 on T+1..T+4, out_valid high 4 cycles, out_last only at T+4, busy high T+1..T+4.
2. Second all-valid capture in the out_last cycle -> 8 continuous out_valid cycles, second vector in order, overflow stays 0.
3. Capture at the 2nd stream cycle -> overflow=1, first stream completes unchanged, no second stream.
4. neuron_valid=4'b0101 -> no output, desync=1; then all-valid -> normal stream.
5. rst_n low during 3rd word -> all outputs 0 asynchronously; after release no residual out_valid; a new capture streams correctly.
6. SER_ARGMAX_EN, words {0xFFF0, 0x0005, 0x0005, 0x0002} -> one cycle after out_last: max_valid=1, max_idx=1, max_val=0x0005. An all-negative vector {0xFFF0,0xFFFE,0xFFF8,0xFFFF} -> max_idx=3.

Source files
------------

// File: rtl/layer_serializer_pkg.sv
// Shared definitions for the layer serializer: default word width, the
// neuron-count to index-width helper, and the FSM state encoding.
package layer_serializer_pkg;

  localparam int NEURON_NUM_DEFAULT = 30;
  localparam int DATA_WIDTH_DEFAULT = 16;

  // Index/counter width for a layer of neuron_num words; never narrower than 1 bit.
  function automatic int idx_width(input int neuron_num);
    return (neuron_num > 2) ? $clog2(neuron_num) : 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running signed maximum over one serial stream; publishes index/value with a
// one-cycle strobe in the cycle after the stream's last word.
module argmax_tracker
  import layer_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int IDX_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  input  logic                  first,
  input  logic                  last,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic [DATA_WIDTH-1:0] val,
  output logic                  strobe
);

  logic [IDX_WIDTH-1:0]  run_idx;
  logic [IDX_WIDTH-1:0]  elem_idx;
  logic [IDX_WIDTH-1:0]  cur_idx;
  logic [IDX_WIDTH-1:0]  win_idx;
  logic [DATA_WIDTH-1:0] run_val;
  logic [DATA_WIDTH-1:0] win_val;
  logic                  take;

  // Word 0 always seeds the maximum; afterwards only a strictly greater value
  // replaces it, so ties keep the lowest index.
  always_comb begin
    cur_idx = first ? '0 : elem_idx;
    take    = first || ($signed(data) > $signed(run_val));
    win_idx = take ? cur_idx : run_idx;
    win_val = take ? data : run_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_idx  <= '0;
      run_val  <= '0;
      elem_idx <= '0;
      idx      <= '0;
      val      <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (valid) begin
        run_idx  <= win_idx;
        run_val  <= win_val;
        elem_idx <= cur_idx + IDX_WIDTH'(1);
        if (last) begin
          idx    <= win_idx;
          val    <= win_val;
          strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/layer_serializer.sv
// Captures a layer's parallel neuron outputs and streams them, index 0 first,
// one word per cycle. Define SER_ARGMAX_EN to add the argmax result ports.
module layer_serializer
  import layer_serializer_pkg::*;
#(
  parameter  int NEURON_NUM = NEURON_NUM_DEFAULT,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  localparam int IDX_WIDTH  = idx_width(NEURON_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NEURON_NUM*DATA_WIDTH-1:0] neuron_data,
  input  logic [NEURON_NUM-1:0]            neuron_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic                             busy,
  output logic                             overflow,
`ifdef SER_ARGMAX_EN
  output logic                             desync,
  output logic [IDX_WIDTH-1:0]             max_idx,
  output logic [DATA_WIDTH-1:0]            max_val,
  output logic                             max_valid
`else
  output logic                             desync
`endif
);

  // Stream protocol: out_valid marks a word the consumer must take in that
  // cycle (there is no ready); out_last marks index NEURON_NUM-1.
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NEURON_NUM - 1);
  localparam int                   VEC_WIDTH = NEURON_NUM * DATA_WIDTH;

  ser_state_t           state;
  logic [IDX_WIDTH-1:0] counter;
  logic [VEC_WIDTH-1:0] shift_reg;
  logic                 all_valid;
  logic                 partial_valid;
  logic                 at_last;

  always_comb begin
    all_valid     = &neuron_valid;
    partial_valid = (|neuron_valid) && !all_valid;
    at_last       = (state == SHIFT) && (counter == LAST_IDX);
  end

  // counter is the index of the word currently on out_data; shift_reg holds
  // the words still to come, next one in the low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      shift_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      desync    <= 1'b0;
    end else begin
      if (partial_valid) begin
        desync <= 1'b1;
      end
      if (all_valid && (state == SHIFT) && !at_last) begin
        overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (all_valid) begin
            state     <= SHIFT;
            counter   <= '0;
            out_data  <= neuron_data[DATA_WIDTH-1:0];
            shift_reg <= neuron_data >> DATA_WIDTH;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end

        SHIFT: begin
          if (at_last && all_valid) begin
            // Back-to-back vector: restart without a gap in out_valid.
            state     <= SHIFT;
            counter   <= '0;
            out_data  <= neuron_data[DATA_WIDTH-1:0];
            shift_reg <= neuron_data >> DATA_WIDTH;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end else if (at_last) begin
            state     <= IDLE;
            counter   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end else begin
            counter   <= counter + IDX_WIDTH'(1);
            out_data  <= shift_reg[DATA_WIDTH-1:0];
            shift_reg <= shift_reg >> DATA_WIDTH;
            out_valid <= 1'b1;
            out_last  <= ((counter + IDX_WIDTH'(1)) == LAST_IDX);
            busy      <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          counter   <= '0;
          out_data  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SER_ARGMAX_EN
  logic first_word;

  always_comb begin
    first_word = out_valid && (counter == '0);
  end

  argmax_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_argmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (out_data),
    .valid  (out_valid),
    .first  (first_word),
    .last   (out_last),
    .idx    (max_idx),
    .val    (max_val),
    .strobe (max_valid)
  );
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// Directed self-checking bench for layer_serializer (NEURON_NUM=4) with a
// scoreboard of expected stream words and, when SER_ARGMAX_EN is set, argmax results.
module tb_layer_serializer;

  localparam int NN = 4;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int EW = DW + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NN*DW-1:0] neuron_data;
  logic [NN-1:0]    neuron_valid;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             overflow;
  logic             desync;
`ifdef SER_ARGMAX_EN
  logic [IW-1:0]    max_idx;
  logic [DW-1:0]    max_val;
  logic             max_valid;
  logic [IW+DW-1:0] max_q[$];
`endif

  logic [EW-1:0]    exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [NN*DW-1:0] vec_a, vec_b, vec_c, vec_d, vec_e, vec_f;

  layer_serializer #(
    .NEURON_NUM (NN),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .neuron_data  (neuron_data),
    .neuron_valid (neuron_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .busy         (busy),
    .overflow     (overflow),
`ifdef SER_ARGMAX_EN
    .desync       (desync),
    .max_idx      (max_idx),
    .max_val      (max_val),
    .max_valid    (max_valid)
`else
    .desync       (desync)
`endif
  );

  // Clock and watchdog
  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NN*DW-1:0] pack4(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // Push the first nwords of a vector; a complete vector also yields an argmax result.
  task automatic push_stream(input logic [NN*DW-1:0] vec, input int nwords);
    logic [DW-1:0]        w;
    int                   best_i;
    logic signed [DW-1:0] best_v;
    best_i = 0;
    best_v = '0;
    for (int i = 0; i < nwords; i++) begin
      w = vec[i*DW +: DW];
      exp_q.push_back({(i == NN - 1), w});
      if (i == 0 || $signed(w) > best_v) begin
        best_v = w;
        best_i = i;
      end
    end
`ifdef SER_ARGMAX_EN
    if (nwords == NN) max_q.push_back({IW'(best_i), best_v});
`endif
  endtask

  // Drivers: inputs change 1 time unit after a rising edge.
  task automatic drive(input logic [NN*DW-1:0] vec, input logic [NN-1:0] vld);
    neuron_data  = vec;
    neuron_valid = vld;
    @(posedge clk);
    #1;
    neuron_valid = '0;
  endtask

  task automatic check_run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'({busy, out_valid}), 32'h3);
    end
  endtask

  task automatic check_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'({busy, out_valid}), 32'h0);
    end
  endtask

  // Scoreboard
  always @(negedge clk) begin : monitor
    logic [EW-1:0]    e;
`ifdef SER_ARGMAX_EN
    logic [IW+DW-1:0] m;
`endif
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(out_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("stream_word", 32'({out_last, out_data}), 32'(e));
        check("busy_in_stream", 32'(busy), 32'h1);
      end
    end else begin
      check("idle_last", 32'(out_last), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
    end
`ifdef SER_ARGMAX_EN
    if (max_valid === 1'b1) begin
      if (max_q.size() == 0) begin
        check("unexpected_max", 32'(max_valid), 32'h0);
      end else begin
        m = max_q.pop_front();
        check("argmax", 32'({max_idx, max_val}), 32'(m));
      end
    end
`endif
  end

  initial begin
    vec_a = pack4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    vec_b = pack4(16'h0100, 16'h0003, 16'h0200, 16'h0001);
    vec_c = pack4(16'h1234, 16'h8000, 16'h7FFF, 16'h0000);
    vec_d = pack4(16'hAAAA, 16'h5555, 16'hCCCC, 16'h3333);
    vec_e = pack4(16'hFFF0, 16'h0005, 16'h0005, 16'h0002);
    vec_f = pack4(16'hFFF0, 16'hFFFE, 16'hFFF8, 16'hFFFF);
    neuron_data  = '0;
    neuron_valid = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 32'({out_valid, out_last, busy, overflow, desync}), 32'h0);
    check("reset_data", 32'(out_data), 32'h0);
`ifdef SER_ARGMAX_EN
    check("reset_max", 32'({max_valid, max_idx, max_val}), 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single stream
    push_stream(vec_a, NN);
    drive(vec_a, '1);
    check_run(NN, "t1_run");
    check_quiet(2, "t1_tail");

    // Back-to-back capture in the out_last cycle
    push_stream(vec_a, NN);
    drive(vec_a, '1);
    fork
      begin
        repeat (NN - 1) @(posedge clk);
        #1;
        push_stream(vec_b, NN);
        drive(vec_b, '1);
      end
      check_run(2 * NN, "t2_run");
    join
    check_quiet(2, "t2_tail");
    check("t2_overflow", 32'(overflow), 32'h0);

    // Capture during the second stream cycle is dropped
    push_stream(vec_c, NN);
    drive(vec_c, '1);
    fork
      begin
        @(posedge clk);
        #1;
        drive(vec_b, '1);
      end
      check_run(NN, "t3_run");
    join
    check_quiet(3, "t3_tail");
    check("t3_overflow", 32'(overflow), 32'h1);
    check("t3_desync", 32'(desync), 32'h0);

    // Partial valid pattern is ignored but flagged
    drive(vec_b, 4'b0101);
    check_quiet(3, "t4_quiet");
    check("t4_desync", 32'(desync), 32'h1);
    push_stream(vec_d, NN);
    drive(vec_d, '1);
    check_run(NN, "t4_run");
    check_quiet(2, "t4_tail");

    // Reset asserted during the third word
    push_stream(vec_d, 2);
    drive(vec_d, '1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_flags", 32'({out_valid, out_last, busy, overflow, desync}), 32'h0);
    check("t5_async_data", 32'(out_data), 32'h0);
`ifdef SER_ARGMAX_EN
    check("t5_async_max", 32'({max_valid, max_idx, max_val}), 32'h0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_quiet(4, "t5_quiet");
    push_stream(vec_a, NN);
    drive(vec_a, '1);
    check_run(NN, "t5_run");
    check_quiet(2, "t5_tail");

`ifdef SER_ARGMAX_EN
    // Argmax timing, tie handling and all-negative vector
    push_stream(vec_e, NN);
    drive(vec_e, '1);
    check_run(NN, "t6_run");
    @(negedge clk);
    check("t6_strobe", 32'({max_valid, max_idx, max_val}), 32'({1'b1, 2'd1, 16'h0005}));
    @(negedge clk);
    check("t6_hold", 32'({max_valid, max_idx, max_val}), 32'({1'b0, 2'd1, 16'h0005}));
    push_stream(vec_f, NN);
    drive(vec_f, '1);
    check_run(NN, "t6_neg_run");
    @(negedge clk);
    check("t6_neg_strobe", 32'({max_valid, max_idx, max_val}), 32'({1'b1, 2'd3, 16'hFFFF}));
`endif

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
`ifdef SER_ARGMAX_EN
    check("max_q_drained", 32'(max_q.size()), 32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
